sync_fifo_fwft: RTL and testbench
=================================

// Module: sync_fifo_fwft
// PURPOSE
//  Single-clock first-word-fall-through FIFO; parametrised successor of the dual-clock FWFT FIFO.
//  Adds fill level, almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow flags.
//  Used for same-domain buffering between stream stages where the CDC cost of the dual-clock FIFO is not needed.
// PARAMETERS
//  DATA_WIDTH     8    data bits per entry
//  ADDR_WIDTH     4    RAM address bits; RAM depth = 2**ADDR_WIDTH; total capacity = 2**ADDR_WIDTH + 1 (RAM + output reg)
//  RESERVE        0    full asserts while RAM free entries <= RESERVE; legal range 0 .. 2**ADDR_WIDTH-1
//  AFULL_THRESH   2**ADDR_WIDTH-2   almost_full = (level >= AFULL_THRESH)
//  AEMPTY_THRESH  2    almost_empty = (level <= AEMPTY_THRESH)
// PORTS
//  clk           in   1             single clock, all logic posedge
//  rst           in   1             asynchronous, active-high reset
//  flush         in   1             synchronous clear of all contents; priority over wr_en/rd_en
//  wr_en         in   1             push wr_data; ignored (dropped) while full
//  wr_data       in   DATA_WIDTH    write data
//  full          out  1             write not accepted this cycle
//  rd_en         in   1             pop the word on rd_data; ignored while has_data=0
//  rd_data       out  DATA_WIDTH    head word, valid while has_data=1 (FWFT)
//  has_data      out  1             rd_data valid
//  empty         out  1             ~has_data
//  level         out  ADDR_WIDTH+1  words held (RAM count + output reg valid)
//  almost_full   out  1             level >= AFULL_THRESH
//  almost_empty  out  1             level <= AEMPTY_THRESH
//  err_clr       in   1             clears sticky error flags
//  overflow      out  1             sticky: wr_en seen while full
//  underflow     out  1             sticky: rd_en seen while has_data=0
// BEHAVIOUR
//  Reset (rst=1, async): pointers, RAM count, out_valid cleared; has_data=0, empty=1, full=0, level=0,
//   almost_empty=1, almost_full=0, overflow=0, underflow=0, rd_data=0. RAM contents undefined, not cleared.
//  Storage: 2**ADDR_WIDTH RAM with registered read + one output register (out_valid). Pointers wrap mod 2**ADDR_WIDTH.
//  full = (ram_count >= 2**ADDR_WIDTH - RESERVE), from current state; write with full=1 dropped even if rd_en same cycle.
//  Write: wr_en & ~full -> mem[wr_ptr]<=wr_data, wr_ptr++, ram_count++ (subject to bypass below).
//  Load: load = (ram_count>0) & (~out_valid | rd_en) -> rd_data<=mem[rd_ptr], rd_ptr++, ram_count--, out_valid<=1.
//  Pop: rd_en & has_data & ~load -> out_valid<=0. rd_data holds last value when has_data=0.
//  Simultaneous wr+load: ram_count unchanged. Back-to-back rd_en sustains one word/cycle while ram_count>0.
//  Latency (no bypass): wr_en sampled at edge k into empty FIFO -> has_data=1 after edge k+1.
//  rd_en with has_data=0: no state change, underflow<=1. Write to empty FIFO with rd_en same cycle: rd_en is underflow.
//  level = ram_count + out_valid, registered-consistent; almost_* combinational from level.
//  flush: next edge clears pointers, ram_count, out_valid; wr/rd that cycle discarded; error flags not affected.
//  err_clr: clears overflow/underflow next edge; a new error in the same cycle wins (flag stays 1).
// CONFIGURATION
//  SYNC_FIFO_FWFT_BYPASS_EN defined: when ram_count==0 and (~out_valid | rd_en&has_data), an accepted write loads
//   rd_data directly; RAM untouched; has_data=1 after edge k (1-edge fall-through).
//  Undefined: every write goes through RAM; 2-edge fall-through as above. Capacity/full identical in both.
// STRUCTURE
//  Package fifo_pkg: LEVEL_W = ADDR_WIDTH+1 helper function, clog2 function, threshold range checks.
//  Sub-module fifo_sdp_ram: simple dual-port RAM, 1 write port, registered read with read enable (maps to block RAM).
//  Top: pointers, ram_count, out_valid, flag logic, bypass mux.
// TESTING
//  Reset mid-traffic (level=5) -> all outputs at reset values same cycle rst rises; flags 0.
//  ADDR_WIDTH=2,RESERVE=0: 6 writes no reads -> level=5, full=1, 6th dropped, overflow=1; read 5 -> order 1..5.
//  Single write 0xA5 to empty -> has_data after edge k+1 (k with BYPASS_EN), rd_data=0xA5; rd_en -> empty=1.
//  Streaming wr+rd every cycle for 1000 cycles at level 3 -> level constant 3, data order intact, no flags.
//  rd_en on empty -> underflow=1, level 0; err_clr -> underflow=0; flush at level 4 -> level=0, empty=1 next edge.
//  RESERVE=1, AFULL_THRESH=3 with ADDR_WIDTH=2 -> full at ram_count=3; almost_full at level 3; almost_empty at level<=2.

Source files
------------

// File: rtl/sync_fifo_fwft_pkg.sv
// Shared helpers for the single-clock FWFT FIFO: level width, clog2 and a
// parameter legality check used at elaboration time by the top level.
package sync_fifo_fwft_pkg;

    // Level counts 0 .. 2**addr_width + 1 (RAM plus output register).
    function automatic int level_w(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // RESERVE must leave at least one usable RAM entry; thresholds must lie
    // within the reachable level range; the level port must hold capacity.
    function automatic bit params_ok(input int data_width, input int addr_width,
                                     input int reserve, input int afull,
                                     input int aempty);
        int cap;
        cap = (1 << addr_width) + 1;
        return (data_width >= 1) && (addr_width >= 1) &&
               (reserve >= 0) && (reserve < (1 << addr_width)) &&
               (afull >= 0) && (afull <= cap) &&
               (aempty >= 0) && (aempty <= cap) &&
               (clog2(cap + 1) <= level_w(addr_width));
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// Stream/status bundle of the single-clock FWFT FIFO.
// master: the producer/consumer side; slave: the FIFO itself.
interface sync_fifo_fwft_if
    import sync_fifo_fwft_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) ();

    logic                             flush;
    logic                             wr_en;
    logic [DATA_WIDTH-1:0]            wr_data;
    logic                             full;
    logic                             rd_en;
    logic [DATA_WIDTH-1:0]            rd_data;
    logic                             has_data;
    logic                             empty;
    logic [level_w(ADDR_WIDTH)-1:0]   level;
    logic                             almost_full;
    logic                             almost_empty;
    logic                             err_clr;
    logic                             overflow;
    logic                             underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en, err_clr,
        input  full, rd_data, has_data, empty, level,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, err_clr,
        output full, rd_data, has_data, empty, level,
               almost_full, almost_empty, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_fwft_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read
// enable. Array has no reset so it maps to block RAM; only the read register
// is reset so the FIFO head reads 0 out of reset.
module fifo_sdp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; holds its value when not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with fill level, almost-full /
// almost-empty thresholds, synchronous flush and sticky overflow/underflow.
// Storage is a 2**ADDR_WIDTH RAM plus the RAM read register acting as the
// output register, so capacity is 2**ADDR_WIDTH + 1 words.
// Build option SYNC_FIFO_FWFT_BYPASS_EN: a write into an empty RAM whose
// output slot is free (or being popped) goes straight to rd_data, giving
// 1-edge fall-through instead of 2.
module sync_fifo_fwft
    import sync_fifo_fwft_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int RESERVE       = 0,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_fwft_if.slave bus
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int LW    = level_w(ADDR_WIDTH);
    localparam logic [LW-1:0] FULL_AT   = LW'(DEPTH - RESERVE);
    localparam logic [LW-1:0] AFULL_L   = LW'(AFULL_THRESH);
    localparam logic [LW-1:0] AEMPTY_L  = LW'(AEMPTY_THRESH);

    if (!params_ok(DATA_WIDTH, ADDR_WIDTH, RESERVE, AFULL_THRESH, AEMPTY_THRESH)) begin : g_param_check
        $error("sync_fifo_fwft: illegal parameter combination");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [LW-1:0]         ram_count;
    logic                  out_valid;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full_i;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  load;
    logic                  byp;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_q;

    // Accept/load/bypass decisions from current state; flush overrides all.
    always_comb begin
        full_i = (ram_count >= FULL_AT);
        wr_acc = bus.wr_en & ~full_i & ~bus.flush;
        rd_acc = bus.rd_en & out_valid & ~bus.flush;
        load   = ~bus.flush & (ram_count != '0) & (~out_valid | bus.rd_en);
`ifdef SYNC_FIFO_FWFT_BYPASS_EN
        byp    = wr_acc & (ram_count == '0) & (~out_valid | rd_acc);
`else
        byp    = 1'b0;
`endif
        ram_we = wr_acc & ~byp;
    end

    // Pointers and RAM occupancy; a write and a load in one cycle cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
        end else if (bus.flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
        end else begin
            if (ram_we) wr_ptr <= wr_ptr + 1'b1;
            if (load)   rd_ptr <= rd_ptr + 1'b1;
            case ({ram_we, load})
                2'b10:   ram_count <= ram_count + 1'b1;
                2'b01:   ram_count <= ram_count - 1'b1;
                default: ram_count <= ram_count;
            endcase
        end
    end

    // Output register valid: set on load/bypass, cleared by a pop with no refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (bus.flush) begin
            out_valid <= 1'b0;
        end else if (load || byp) begin
            out_valid <= 1'b1;
        end else if (rd_acc) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error flags; a fresh error beats err_clr in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (overflow_q  & ~bus.err_clr) | (bus.wr_en & full_i & ~bus.flush);
            underflow_q <= (underflow_q & ~bus.err_clr) | (bus.rd_en & ~out_valid & ~bus.flush);
        end
    end

    fifo_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .re    (load),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

`ifdef SYNC_FIFO_FWFT_BYPASS_EN
    logic [DATA_WIDTH-1:0] byp_data;
    logic                  sel_byp;

    // Bypass capture; head source flips back to RAM on the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_data <= '0;
            sel_byp  <= 1'b0;
        end else if (byp) begin
            byp_data <= bus.wr_data;
            sel_byp  <= 1'b1;
        end else if (load) begin
            sel_byp  <= 1'b0;
        end
    end

    assign bus.rd_data = sel_byp ? byp_data : ram_q;
`else
    assign bus.rd_data = ram_q;
`endif

    assign bus.full         = full_i;
    assign bus.has_data     = out_valid;
    assign bus.empty        = ~out_valid;
    assign bus.level        = ram_count + LW'(out_valid);
    assign bus.almost_full  = (bus.level >= AFULL_L);
    assign bus.almost_empty = (bus.level <= AEMPTY_L);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft. Writes push expected words into a
// scoreboard queue; a negedge monitor pops and compares on every real pop.
module tb_sync_fifo_fwft;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fails = 0;
    logic [7:0] exp_q[$];

    // A: ADDR_WIDTH=2, RESERVE=0, AFULL=2 (default), AEMPTY=2
    sync_fifo_fwft_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) a_if ();
    sync_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .RESERVE(0)) dut_a (
        .clk (clk), .rst (rst), .bus (a_if));

    // B: ADDR_WIDTH=2, RESERVE=1, AFULL=3, AEMPTY=2
    sync_fifo_fwft_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) b_if ();
    sync_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .RESERVE(1),
                     .AFULL_THRESH(3), .AEMPTY_THRESH(2)) dut_b (
        .clk (clk), .rst (rst), .bus (b_if));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_has_data"}, a_if.has_data, 0);
        chk({tag, "_empty"},    a_if.empty, 1);
        chk({tag, "_full"},     a_if.full, 0);
        chk({tag, "_level"},    a_if.level, 0);
        chk({tag, "_aempty"},   a_if.almost_empty, 1);
        chk({tag, "_afull"},    a_if.almost_full, 0);
        chk({tag, "_ovf"},      a_if.overflow, 0);
        chk({tag, "_udf"},      a_if.underflow, 0);
        chk({tag, "_rd_data"},  a_if.rd_data, 0);
    endtask

    // Scoreboard monitor: a pop happens at the next edge when rd_en & has_data.
    always @(negedge clk) begin
        if (!rst && a_if.has_data && a_if.rd_en && !a_if.flush) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fails++;
                $display("FAIL pop_data: got %0h, expected no word (queue empty)", a_if.rd_data);
            end else begin
                chk("pop_data", a_if.rd_data, exp_q.pop_front());
            end
        end
    end

    int b_lvl [5] = '{1, 2, 3, 4, 4};
    int b_full[5] = '{0, 0, 0, 1, 1};
    int b_af  [5] = '{0, 0, 1, 1, 1};
    int b_ae  [5] = '{1, 1, 0, 0, 0};

    initial begin
        a_if.flush = 0; a_if.wr_en = 0; a_if.wr_data = 0; a_if.rd_en = 0; a_if.err_clr = 0;
        b_if.flush = 0; b_if.wr_en = 0; b_if.wr_data = 0; b_if.rd_en = 0; b_if.err_clr = 0;
        repeat (3) tick();
        chk_reset_a("reset");
        rst = 0;
        tick();

        // Fill: 6 writes, capacity 5, 6th dropped.
        for (int i = 1; i <= 6; i++) begin
            a_if.wr_en = 1; a_if.wr_data = 8'(i);
            if (i <= 5) exp_q.push_back(8'(i));
            tick();
        end
        a_if.wr_en = 0;
        chk("fill_level", a_if.level, 5);
        chk("fill_full", a_if.full, 1);
        chk("fill_ovf", a_if.overflow, 1);
        chk("fill_afull", a_if.almost_full, 1);
        chk("fill_aempty", a_if.almost_empty, 0);
        a_if.rd_en = 1;
        repeat (5) tick();
        a_if.rd_en = 0;
        chk("drain_empty", a_if.empty, 1);
        chk("drain_level", a_if.level, 0);
        chk("drain_udf", a_if.underflow, 0);
        a_if.err_clr = 1; tick(); a_if.err_clr = 0;
        chk("errclr_ovf", a_if.overflow, 0);

        // Single word latency.
        a_if.wr_en = 1; a_if.wr_data = 8'hA5; exp_q.push_back(8'hA5);
        tick();
        a_if.wr_en = 0;
`ifdef SYNC_FIFO_FWFT_BYPASS_EN
        chk("lat_edge_k", a_if.has_data, 1);
`else
        chk("lat_edge_k", a_if.has_data, 0);
`endif
        tick();
        chk("lat_edge_k1", a_if.has_data, 1);
        chk("lat_data", a_if.rd_data, 8'hA5);
        a_if.rd_en = 1; tick(); a_if.rd_en = 0;
        chk("single_empty", a_if.empty, 1);

        // Streaming at level 3.
        for (int i = 0; i < 3; i++) begin
            a_if.wr_en = 1; a_if.wr_data = 8'(8'h10 + i); exp_q.push_back(8'(8'h10 + i));
            tick();
        end
        chk("stream_prefill", a_if.level, 3);
        for (int i = 0; i < 1000; i++) begin
            a_if.wr_en = 1; a_if.rd_en = 1;
            a_if.wr_data = 8'(8'h13 + i); exp_q.push_back(8'(8'h13 + i));
            tick();
            chk("stream_level", a_if.level, 3);
        end
        a_if.wr_en = 0;
        repeat (3) tick();
        a_if.rd_en = 0;
        chk("stream_empty", a_if.empty, 1);
        chk("stream_ovf", a_if.overflow, 0);
        chk("stream_udf", a_if.underflow, 0);

        // Underflow, err_clr, and error-beats-clear.
        a_if.rd_en = 1; tick(); a_if.rd_en = 0;
        chk("udf_set", a_if.underflow, 1);
        chk("udf_level", a_if.level, 0);
        a_if.rd_en = 1; a_if.err_clr = 1; tick(); a_if.rd_en = 0;
        chk("udf_err_wins", a_if.underflow, 1);
        tick(); a_if.err_clr = 0;
        chk("udf_cleared", a_if.underflow, 0);

        // Flush at level 4 with wr/rd in the same cycle.
        for (int i = 0; i < 4; i++) begin
            a_if.wr_en = 1; a_if.wr_data = 8'(8'h20 + i);
            tick();
        end
        a_if.wr_en = 0;
        chk("preflush_level", a_if.level, 4);
        a_if.flush = 1; a_if.wr_en = 1; a_if.wr_data = 8'h99; a_if.rd_en = 1;
        tick();
        a_if.flush = 0; a_if.wr_en = 0; a_if.rd_en = 0;
        chk("flush_level", a_if.level, 0);
        chk("flush_empty", a_if.empty, 1);
        chk("flush_udf", a_if.underflow, 0);
        a_if.wr_en = 1; a_if.wr_data = 8'h3C; exp_q.push_back(8'h3C);
        tick();
        a_if.wr_en = 0;
        tick();
        chk("postflush_has", a_if.has_data, 1);
        a_if.rd_en = 1; tick(); a_if.rd_en = 0;
        chk("postflush_empty", a_if.empty, 1);

        // Reset mid-traffic at level 5, plus a sticky flag set beforehand.
        for (int i = 0; i < 6; i++) begin
            a_if.wr_en = 1; a_if.wr_data = 8'(8'h40 + i);
            tick();
        end
        a_if.wr_en = 0;
        chk("prerst_level", a_if.level, 5);
        chk("prerst_ovf", a_if.overflow, 1);
        @(posedge clk); #3;
        rst = 1;
        #1;
        chk_reset_a("midrst");
        tick();
        rst = 0;
        tick();

        // RESERVE=1, AFULL=3 thresholds on B.
        for (int i = 0; i < 5; i++) begin
            b_if.wr_en = 1; b_if.wr_data = 8'(i);
            tick();
            chk("b_level", b_if.level, b_lvl[i]);
            chk("b_full", b_if.full, b_full[i]);
            chk("b_afull", b_if.almost_full, b_af[i]);
            chk("b_aempty", b_if.almost_empty, b_ae[i]);
        end
        b_if.wr_en = 0;
        chk("b_ovf", b_if.overflow, 1);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
